delay_line_param: RTL and testbench
===================================

DELAY_LINE_PARAM -- requirements
Module: delay_line_param

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width in bits (1..64).
REQ-002 SHALL have parameter MAX_DEPTH, default 16, number of physical delay stages (2..256).
REQ-003 SHALL have parameter DEFAULT_DELAY, default 6, delay after reset (1..MAX_DEPTH).
REQ-004 SHALL have parameter DW, default clog2(MAX_DEPTH+1), width of the delay config field.
REQ-005 SHALL have port clock  input  1  sole clock, rising-edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port en  input  1  pipeline advance enable; 0 = hold all stages.
REQ-008 SHALL have port in_data  input  WIDTH  data word entering stage 0.
REQ-009 SHALL have port in_valid  input  1  qualifies in_data.
REQ-010 SHALL have port cfg_load  input  1  single-cycle pulse; applies cfg_delay.
REQ-011 SHALL have port cfg_delay  input  DW  requested delay, legal 1..MAX_DEPTH.
REQ-012 SHALL have port out_data  output  WIDTH  word from tap D.
REQ-013 SHALL have port out_valid  output  1  qualifies out_data.
REQ-014 SHALL have port busy  output  1  any valid word held in stages 1..D.
REQ-015 SHALL have port cur_delay  output  DW  active delay D.
REQ-016 SHALL have port cfg_err  output  1  sticky illegal-config flag.

Function
REQ-017 SHALL hold MAX_DEPTH data stages s[1..MAX_DEPTH] with matching valid bits v[1..MAX_DEPTH].
REQ-018 When en=1 and cfg_load=0 at a clock edge, SHALL shift s[1]<=in_data, v[1]<=in_valid, s[i]<=s[i-1], v[i]<=v[i-1] for i=2..MAX_DEPTH.
REQ-019 When en=0 and cfg_load=0, SHALL hold all stages and valid bits unchanged.
REQ-020 SHALL drive out_data=s[D] and out_valid=v[D], selected combinationally from registers; no logic from in_* to out_* (latency exactly D enabled edges).
REQ-021 Words SHALL be passed unmodified: no bit rotation, sign change or truncation.
REQ-022 busy SHALL equal OR of v[1..D]; stages beyond D SHALL NOT affect busy or outputs.
REQ-023 On cfg_load=1 with 1<=cfg_delay<=MAX_DEPTH, SHALL set D<=cfg_delay at that edge.
REQ-024 On cfg_load=1 with cfg_delay=0, SHALL set D<=1 and cfg_err<=1.
REQ-025 On cfg_load=1 with cfg_delay>MAX_DEPTH, SHALL set D<=MAX_DEPTH and cfg_err<=1.
REQ-026 On any cfg_load=1, SHALL clear all v[i] at that edge (flush); s[i] data MAY retain stale values; in_data/in_valid that cycle SHALL be dropped regardless of en.
REQ-027 cfg_err SHALL remain 1 until reset; a later legal cfg_load SHALL NOT clear it.
REQ-028 cur_delay SHALL equal the registered D, updating the cycle after cfg_load.
REQ-029 First in_valid word after cfg_load SHALL appear on out_valid exactly D enabled edges after its capture edge.
REQ-030 Back-to-back cfg_load pulses SHALL each flush; the last one determines D.

Reset
REQ-031 On reset=1 at a clock edge, SHALL set all v[i]=0, all s[i]=0, D=DEFAULT_DELAY, cfg_err=0.
REQ-032 After reset: out_data=0, out_valid=0, busy=0, cur_delay=DEFAULT_DELAY, cfg_err=0.
REQ-033 reset SHALL take priority over cfg_load and en in the same cycle.
REQ-034 Reset asserted mid-stream SHALL discard all in-flight words; no pre-reset word SHALL ever appear with out_valid=1.

Verification
REQ-035 Reset, en=1, in_valid=1, in_data=0x0001..0x0010 on consecutive cycles -> out_valid rises 6 cycles after first capture, out_data=0x0001..0x0010 in order, no gaps.
REQ-036 cfg_load with cfg_delay=3, then stream 0xA5A5,0x5A5A -> cur_delay=3, 0xA5A5 out 3 edges after capture, cfg_err=0.
REQ-037 Stream at D=6, toggle en=0 for 4 cycles mid-stream -> outputs frozen during stall, words exit 10 cycles after capture, order preserved.
REQ-038 cfg_load with cfg_delay=0, then cfg_delay=MAX_DEPTH+1 -> cur_delay=1 then 16, cfg_err=1 and stays 1 after a legal load of 4.
REQ-039 Four valid words in flight at D=6, pulse cfg_load (cfg_delay=6) -> busy=0 and out_valid=0 next cycle; none of the four words ever emerges.
REQ-040 Reset asserted with cfg_load=1 and valid data in flight -> cur_delay=6, cfg_err=0, out_valid=0, busy=0.

Source files
------------

// File: rtl/delay_line_param.sv
// Programmable-tap delay line: MAX_DEPTH physical stages, output taken from stage D.
// D is reprogrammed with a cfg_load pulse, which also flushes every in-flight word.
module delay_line_param #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned MAX_DEPTH     = 16,
  parameter int unsigned DEFAULT_DELAY = 6,
  parameter int unsigned DW            = $clog2(MAX_DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             cfg_load,
  input  logic [DW-1:0]    cfg_delay,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             busy,
  output logic [DW-1:0]    cur_delay,
  output logic             cfg_err
);

  // Stage i holds the word captured i-1 enabled edges ago.
  logic [WIDTH-1:0]   data_q [1:MAX_DEPTH];
  logic [MAX_DEPTH:1] valid_q;
  logic [DW-1:0]      delay_q, delay_d;
  logic               err_q, err_d;

  // Clamp the requested delay into 1..MAX_DEPTH; anything outside sets the sticky error.
  always_comb begin
    delay_d = cfg_delay;
    err_d   = err_q;
    if (cfg_delay == '0) begin
      delay_d = DW'(1);
      err_d   = 1'b1;
    end else if (32'(cfg_delay) > MAX_DEPTH) begin
      delay_d = DW'(MAX_DEPTH);
      err_d   = 1'b1;
    end
  end

  // Pipeline and config state; reset beats cfg_load, which beats the enabled shift.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 1; i <= int'(MAX_DEPTH); i++) begin
        data_q[i] <= '0;
      end
      valid_q <= '0;
      delay_q <= DW'(DEFAULT_DELAY);
      err_q   <= 1'b0;
    end else if (cfg_load) begin
      // Flush only the valid bits; stale data is harmless once unqualified.
      valid_q <= '0;
      delay_q <= delay_d;
      err_q   <= err_d;
    end else if (en) begin
      data_q[1] <= in_data;
      for (int i = 2; i <= int'(MAX_DEPTH); i++) begin
        data_q[i] <= data_q[i-1];
      end
      valid_q <= {valid_q[MAX_DEPTH-1:1], in_valid};
    end
  end

  // Tap select and busy reduction; stages past D are ignored entirely.
  always_comb begin
    out_data  = '0;
    out_valid = 1'b0;
    busy      = 1'b0;
    for (int i = 1; i <= int'(MAX_DEPTH); i++) begin
      if (i == int'(delay_q)) begin
        out_data  = data_q[i];
        out_valid = valid_q[i];
      end
      if (i <= int'(delay_q)) begin
        busy = busy | valid_q[i];
      end
    end
  end

  assign cur_delay = delay_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_delay_line_param.sv
// Directed bench for delay_line_param with a latency-tagged scoreboard.
module tb_delay_line_param;

  localparam int W  = 16;
  localparam int MD = 16;
  localparam int DW = 5;

  logic          clock = 1'b0;
  logic          reset, en, in_valid, cfg_load;
  logic [W-1:0]  in_data;
  logic [DW-1:0] cfg_delay;
  logic [W-1:0]  out_data;
  logic          out_valid, busy, cfg_err;
  logic [DW-1:0] cur_delay;

  typedef struct {
    logic [W-1:0] data;
    int           exit_edge;
  } item_t;

  item_t sb[$];
  int    edge_cnt  = 0;
  int    exp_delay = 6;
  logic  exp_err   = 1'b0;
  int    n_assert  = 0;
  int    n_fail    = 0;

  delay_line_param #(
    .WIDTH(W), .MAX_DEPTH(MD), .DEFAULT_DELAY(6), .DW(DW)
  ) dut (
    .clock(clock), .reset(reset), .en(en), .in_data(in_data), .in_valid(in_valid),
    .cfg_load(cfg_load), .cfg_delay(cfg_delay), .out_data(out_data), .out_valid(out_valid),
    .busy(busy), .cur_delay(cur_delay), .cfg_err(cfg_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the reference model at the edge, then check outputs.
  task automatic step(input logic e, input logic v, input logic [W-1:0] d,
                      input logic cl, input logic [DW-1:0] cd, input logic rst);
    logic exp_v;
    @(negedge clock);
    en = e; in_valid = v; in_data = d; cfg_load = cl; cfg_delay = cd; reset = rst;
    @(posedge clock);
    if (rst) begin
      sb.delete();
      exp_delay = 6;
      exp_err   = 1'b0;
    end else if (cl) begin
      sb.delete();
      if (cd == 0) begin
        exp_delay = 1;
        exp_err   = 1'b1;
      end else if (int'(cd) > MD) begin
        exp_delay = MD;
        exp_err   = 1'b1;
      end else begin
        exp_delay = int'(cd);
      end
    end else if (e) begin
      edge_cnt++;
      // Captured into stage 1 now; reaches stage D after D-1 further enabled edges.
      if (v) sb.push_back('{data: d, exit_edge: edge_cnt + exp_delay - 1});
    end
    #1;
    while (sb.size() > 0 && sb[0].exit_edge < edge_cnt) void'(sb.pop_front());
    exp_v = (sb.size() > 0) && (sb[0].exit_edge == edge_cnt);
    chk("out_valid", 32'(out_valid), 32'(exp_v));
    if (exp_v) chk("out_data", 32'(out_data), 32'(sb[0].data));
    chk("busy", 32'(busy), 32'(sb.size() > 0));
    chk("cur_delay", 32'(cur_delay), 32'(exp_delay));
    chk("cfg_err", 32'(cfg_err), 32'(exp_err));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0, 1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    // Reset and post-reset state, including a zero output word.
    step(1'b0, 1'b0, 16'h0, 1'b0, 5'd0, 1'b1);
    step(1'b1, 1'b0, 16'h0, 1'b0, 5'd0, 1'b1);
    chk("reset_out_data", 32'(out_data), 32'h0);

    // Continuous stream at the default delay of 6.
    for (int i = 1; i <= 16; i++) step(1'b1, 1'b1, 16'(i), 1'b0, 5'd0, 1'b0);
    idle(8);

    // Legal reprogram to 3.
    step(1'b1, 1'b0, 16'h0, 1'b1, 5'd3, 1'b0);
    step(1'b1, 1'b1, 16'hA5A5, 1'b0, 5'd0, 1'b0);
    step(1'b1, 1'b1, 16'h5A5A, 1'b0, 5'd0, 1'b0);
    idle(5);

    // Back at 6, stall four cycles mid-stream with junk on the inputs.
    step(1'b1, 1'b0, 16'h0, 1'b1, 5'd6, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 16'h1000 + 16'(i), 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'hBAD0 + 16'(i), 1'b0, 5'd0, 1'b0);
    for (int i = 4; i < 8; i++) step(1'b1, 1'b1, 16'h1000 + 16'(i), 1'b0, 5'd0, 1'b0);
    idle(10);

    // Flush with four words in flight; the cycle's own input is dropped too.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 16'hC000 + 16'(i), 1'b0, 5'd0, 1'b0);
    step(1'b1, 1'b1, 16'hDEAD, 1'b1, 5'd6, 1'b0);
    idle(10);

    // Illegal loads: 0 clamps to 1, 17 clamps to 16; error stays through a legal load.
    step(1'b1, 1'b0, 16'h0, 1'b1, 5'd0, 1'b0);
    step(1'b1, 1'b1, 16'h0D01, 1'b0, 5'd0, 1'b0);
    step(1'b1, 1'b1, 16'h0D02, 1'b0, 5'd0, 1'b0);
    idle(2);
    step(1'b1, 1'b0, 16'h0, 1'b1, 5'd17, 1'b0);
    step(1'b1, 1'b1, 16'hFFFF, 1'b0, 5'd0, 1'b0);
    idle(17);
    step(1'b1, 1'b0, 16'h0, 1'b1, 5'd4, 1'b0);

    // Mixed traffic at D=4: gaps in valid and enable, pseudo-random data.
    for (int i = 0; i < 24; i++)
      step(1'(i % 5 != 3), 1'(i % 3 != 1), 16'($urandom), 1'b0, 5'd0, 1'b0);
    idle(6);

    // Back-to-back loads: both flush, the second sets D.
    step(1'b1, 1'b1, 16'h7777, 1'b0, 5'd0, 1'b0);
    step(1'b1, 1'b1, 16'h1111, 1'b1, 5'd2, 1'b0);
    step(1'b1, 1'b1, 16'h2222, 1'b1, 5'd5, 1'b0);
    step(1'b1, 1'b1, 16'h8001, 1'b0, 5'd0, 1'b0);
    idle(6);

    // Reset wins over cfg_load with words in flight; none of them may emerge.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'hE000 + 16'(i), 1'b0, 5'd0, 1'b0);
    step(1'b1, 1'b1, 16'hEEEE, 1'b1, 5'd2, 1'b1);
    chk("reset_prio_out_data", 32'(out_data), 32'h0);
    idle(10);
    step(1'b1, 1'b1, 16'h4242, 1'b0, 5'd0, 1'b0);
    idle(7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
